// File: rtl/match_round_ctrl_pkg.sv
// Shared game types: the over code seen by movers and draw_gameover, the
// is_gameover result encoding, and the match controller state set.
package match_round_ctrl_pkg;

  typedef enum logic [1:0] {
    OVER_NONE  = 2'b00,
    OVER_TOM   = 2'b01,
    OVER_JERRY = 2'b10
  } over_t;

  localparam logic [1:0] GO_NONE  = 2'b00;
  localparam logic [1:0] GO_TOM   = 2'b01;
  localparam logic [1:0] GO_JERRY = 2'b10;
  localparam logic [1:0] GO_BOTH  = 2'b11;

  typedef enum logic [1:0] {
    PLAY,
    FREEZE,
    MATCH_END
  } state_t;

  // A simultaneous catch and cheese win goes to tom.
  function automatic over_t decode_result(input logic [1:0] result);
    over_t winner;
    case (result)
      GO_TOM, GO_BOTH: winner = OVER_TOM;
      GO_JERRY:        winner = OVER_JERRY;
      default:         winner = OVER_NONE;
    endcase
    return winner;
  endfunction

endpackage

// File: rtl/match_round_ctrl_frame_tick_gen.sv
// Rising-edge detector on vsync: one clk-wide tick per frame.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic tick
);

  logic vsync_q;

  always_ff @(posedge clk) begin
    if (rst) vsync_q <= 1'b0;
    else     vsync_q <= vsync;
  end

  assign tick = vsync & ~vsync_q;

endmodule

// File: rtl/match_round_ctrl.sv
// Best-of-N match controller between is_gameover and the movers/draw_gameover.
// Define MATCH_TIMEOUT_EN to give each round a frame budget that jerry wins on expiry.
module match_round_ctrl
  import match_round_ctrl_pkg::*;
#(
  parameter int ROUNDS_TO_WIN = 3,
  parameter int FREEZE_FRAMES = 120,
  parameter int ROUND_FRAMES  = 1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reset,
  input  logic        vsync,
  input  logic [1:0]  gameover,
  output logic [1:0]  over,
  output logic        round_restart,
  output logic [2:0]  tom_wins,
  output logic [2:0]  jerry_wins,
  output logic        match_over,
  output logic [11:0] frames_left
);

  if (ROUNDS_TO_WIN < 1 || ROUNDS_TO_WIN > 7) begin : g_bad_rounds
    $error("match_round_ctrl: ROUNDS_TO_WIN out of range");
  end
  if (FREEZE_FRAMES < 1 || FREEZE_FRAMES > 255) begin : g_bad_freeze
    $error("match_round_ctrl: FREEZE_FRAMES out of range");
  end
  if (ROUND_FRAMES < 1 || ROUND_FRAMES > 4095) begin : g_bad_round_frames
    $error("match_round_ctrl: ROUND_FRAMES out of range");
  end

  localparam logic [2:0] WIN_TARGET  = 3'(ROUNDS_TO_WIN);
  localparam logic [7:0] FREEZE_LOAD = 8'(FREEZE_FRAMES);
`ifdef MATCH_TIMEOUT_EN
  localparam logic [11:0] FRAME_LOAD = 12'(ROUND_FRAMES);
`else
  localparam logic [11:0] FRAME_LOAD = 12'd0;
`endif

  logic tick;

  frame_tick_gen u_frame_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .vsync (vsync),
    .tick  (tick)
  );

  state_t      state_q, state_d;
  over_t       over_q, over_d;
  logic        restart_q, restart_d;
  logic [2:0]  tom_q, tom_d;
  logic [2:0]  jerry_q, jerry_d;
  logic        match_q, match_d;
  logic [11:0] frames_q, frames_d;
  logic [7:0]  freeze_q, freeze_d;
  over_t       winner;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PLAY;
      over_q    <= OVER_NONE;
      restart_q <= 1'b0;
      tom_q     <= 3'd0;
      jerry_q   <= 3'd0;
      match_q   <= 1'b0;
      frames_q  <= FRAME_LOAD;
      freeze_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      over_q    <= over_d;
      restart_q <= restart_d;
      tom_q     <= tom_d;
      jerry_q   <= jerry_d;
      match_q   <= match_d;
      frames_q  <= frames_d;
      freeze_q  <= freeze_d;
    end
  end

  // The keyboard restart overrides anything else happening in the same clk.
  always_comb begin
    state_d   = state_q;
    over_d    = over_q;
    restart_d = 1'b0;
    tom_d     = tom_q;
    jerry_d   = jerry_q;
    match_d   = match_q;
    frames_d  = frames_q;
    freeze_d  = freeze_q;
    winner    = OVER_NONE;

    if (reset) begin
      state_d   = PLAY;
      over_d    = OVER_NONE;
      restart_d = 1'b1;
      tom_d     = 3'd0;
      jerry_d   = 3'd0;
      match_d   = 1'b0;
      frames_d  = FRAME_LOAD;
      freeze_d  = 8'd0;
    end else begin
      case (state_q)
        PLAY: begin
          winner = decode_result(gameover);
`ifdef MATCH_TIMEOUT_EN
          if (tick && frames_q != 12'd0) begin
            frames_d = frames_q - 12'd1;
            if (frames_q == 12'd1 && winner == OVER_NONE) winner = OVER_JERRY;
          end
`endif
          if (winner != OVER_NONE) begin
            over_d   = winner;
            freeze_d = FREEZE_LOAD;
            state_d  = FREEZE;
            if (winner == OVER_TOM) begin
              if (tom_q < WIN_TARGET) tom_d = tom_q + 3'd1;
            end else begin
              if (jerry_q < WIN_TARGET) jerry_d = jerry_q + 3'd1;
            end
          end
        end

        FREEZE: begin
          if (tom_q == WIN_TARGET || jerry_q == WIN_TARGET) begin
            state_d = MATCH_END;
            match_d = 1'b1;
          end else if (tick) begin
            if (freeze_q <= 8'd1) begin
              freeze_d  = 8'd0;
              restart_d = 1'b1;
              over_d    = OVER_NONE;
              frames_d  = FRAME_LOAD;
              state_d   = PLAY;
            end else begin
              freeze_d = freeze_q - 8'd1;
            end
          end
        end

        MATCH_END: begin
        end

        default: state_d = PLAY;
      endcase
    end
  end

  assign over          = over_q;
  assign round_restart = restart_q;
  assign tom_wins      = tom_q;
  assign jerry_wins    = jerry_q;
  assign match_over    = match_q;
  assign frames_left   = frames_q;

endmodule
